// File: rtl/dawson64_if_pkg.sv
// Shared definitions for the Dawson FPU adapter.
//   DW      : operand/result width (IEEE-754 double).
//   state_e : adapter sequencing states.
package dawson_pkg;

    localparam int DW = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_WAIT_Z = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/dawson64_if.sv
// dawson64_if: adapts a single-cycle request/ready pulse interface to the
// strobe/ack handshake of a Dawson-style FPU (adder, multiplier, divider).
// The FPU lives next to this block; only its handshake is driven from here.
//
// Ports:
//   clock, reset_n           : system clock, async active-low reset
//   a, b, ready_in           : operands, captured on the ready_in pulse
//   out, ready_out           : result register and one-cycle completion pulse
//   clk, rst                 : FPU clock (= clock) and sync reset (= ~reset_n)
//   input_a/_stb/_ack        : operand A transfer to the FPU
//   input_b/_stb/_ack        : operand B transfer to the FPU
//   output_z/_stb/_ack       : result transfer from the FPU
module dawson64_if
    import dawson_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          ready_in,
    output logic [DW-1:0] out,
    output logic          ready_out,
    output logic          clk,
    output logic          rst,
    output logic [DW-1:0] input_a,
    output logic          input_a_stb,
    input  logic          input_a_ack,
    output logic [DW-1:0] input_b,
    output logic          input_b_stb,
    input  logic          input_b_ack,
    input  logic [DW-1:0] output_z,
    input  logic          output_z_stb,
    output logic          output_z_ack
);

    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] out_q, out_d;
    logic          a_stb_q, a_stb_d;
    logic          b_stb_q, b_stb_d;
    logic          z_ack_q, z_ack_d;
    logic          ready_out_q, ready_out_d;

    // The FPU shares our clock and is held in reset for as long as we are.
    assign clk = clock;
    assign rst = ~reset_n;

    // Handshake outputs are registered and computed alongside the next
    // state, so each strobe/ack is high exactly while in its own state.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        a_stb_d     = 1'b0;
        b_stb_d     = 1'b0;
        z_ack_d     = 1'b0;
        ready_out_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ready_in) begin
                    // Operands need not stay stable after the request cycle.
                    a_d     = a;
                    b_d     = b;
                    a_stb_d = 1'b1;
                    state_d = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                if (a_stb_q && input_a_ack) begin
                    b_stb_d = 1'b1;
                    state_d = ST_SEND_B;
                end else begin
                    a_stb_d = 1'b1;
                end
            end
            ST_SEND_B: begin
                if (b_stb_q && input_b_ack) begin
                    z_ack_d = 1'b1;
                    state_d = ST_WAIT_Z;
                end else begin
                    b_stb_d = 1'b1;
                end
            end
            ST_WAIT_Z: begin
                // No timeout: the FPU is trusted to eventually respond.
                if (z_ack_q && output_z_stb) begin
                    out_d       = output_z;
                    ready_out_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    z_ack_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            a_stb_q     <= 1'b0;
            b_stb_q     <= 1'b0;
            z_ack_q     <= 1'b0;
            ready_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
            z_ack_q     <= z_ack_d;
            ready_out_q <= ready_out_d;
        end
    end

    assign out          = out_q;
    assign ready_out    = ready_out_q;
    assign input_a      = a_q;
    assign input_b      = b_q;
    assign input_a_stb  = a_stb_q;
    assign input_b_stb  = b_stb_q;
    assign output_z_ack = z_ack_q;

endmodule

// File: tb/tb_dawson64_if.sv
// Bench for dawson64_if: a behavioural double-adder FPU with programmable
// ack/compute stalls, a request driver that queues expected sums, and a
// monitor that pops and compares on every ready_out.
module tb_dawson64_if;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        ready_in = 1'b0;
    logic [63:0] out;
    logic        ready_out;
    logic        clk;
    logic        rst;
    logic [63:0] input_a;
    logic [63:0] input_b;
    logic        input_a_stb;
    logic        input_b_stb;
    logic        input_a_ack;
    logic        input_b_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    always #5 clock = ~clock;

    dawson64_if dut (
        .clock(clock), .reset_n(reset_n), .a(a), .b(b), .ready_in(ready_in),
        .out(out), .ready_out(ready_out), .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        busy = 1'b0;
    logic [63:0] last_out = '0;
    logic        prev_ro = 1'b0;
    int          n_done = 0;
    int          a_dly = 0, b_dly = 0, c_dly = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] dsum(input logic [63:0] x, input logic [63:0] y);
        return $realtobits($bitstoreal(x) + $bitstoreal(y));
    endfunction

    function automatic logic [63:0] rnd_dbl();
        real r;
        r = real'($urandom_range(0, 2000000)) / 7.0 - 140000.0;
        return $realtobits(r);
    endfunction

    // Behavioural FPU: acks each operand after a programmable stall,
    // then presents the sum after a programmable compute delay.
    int          ph = 0;
    int          cnt = 0;
    logic [63:0] fa = '0;
    always @(posedge clock) begin
        if (rst) begin
            ph <= 0; cnt <= 0;
            input_a_ack <= 1'b0; input_b_ack <= 1'b0;
            output_z_stb <= 1'b0; output_z <= '0;
        end else begin
            chk(!(ph != 0 && input_a_stb), "a_stb_out_of_turn", 64'(input_a_stb), 64'd0);
            chk(!(ph != 1 && input_b_stb), "b_stb_out_of_turn", 64'(input_b_stb), 64'd0);
            case (ph)
                0: if (input_a_ack && input_a_stb) begin
                       fa <= input_a; input_a_ack <= 1'b0; ph <= 1; cnt <= 0;
                   end else if (input_a_stb) begin
                       if (cnt >= a_dly) input_a_ack <= 1'b1;
                       cnt <= cnt + 1;
                   end else if (cnt != 0) begin
                       chk(1'b0, "a_stb_dropped_before_ack", 64'd0, 64'd1);
                   end
                1: if (input_b_ack && input_b_stb) begin
                       output_z <= dsum(fa, input_b); input_b_ack <= 1'b0; ph <= 2; cnt <= 0;
                   end else if (input_b_stb) begin
                       if (cnt >= b_dly) input_b_ack <= 1'b1;
                       cnt <= cnt + 1;
                   end else if (cnt != 0) begin
                       chk(1'b0, "b_stb_dropped_before_ack", 64'd0, 64'd1);
                   end
                2: if (cnt >= c_dly) begin output_z_stb <= 1'b1; ph <= 3; end
                   else cnt <= cnt + 1;
                default: if (output_z_stb && output_z_ack) begin
                       output_z_stb <= 1'b0; ph <= 0; cnt <= 0;
                   end
            endcase
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clock) begin
        logic [63:0] e;
        #1;
        chk(rst === ~reset_n, "rst_follows_reset_n", 64'(rst), 64'(~reset_n));
        chk(clk === clock, "clk_equals_clock", 64'(clk), 64'(clock));
        if (!reset_n) begin
            exp_q.delete();
            busy = 1'b0;
            last_out = '0;
            prev_ro = 1'b0;
        end else begin
            if (ready_out) begin
                chk(!prev_ro, "ready_out_single_cycle", 64'(prev_ro), 64'd0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_ready_out", out, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(out === e, "out_value", out, e);
                end
                last_out = out;
                busy = 1'b0;
                n_done++;
            end else begin
                chk(out === last_out, "out_hold", out, last_out);
            end
            chk(!(input_a_stb && input_b_stb), "a_b_stb_overlap", 64'(input_b_stb), 64'd0);
            chk(!(output_z_ack && (input_a_stb || input_b_stb)), "z_ack_overlap", 64'(output_z_ack), 64'd0);
            prev_ro = ready_out;
        end
    end

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 500) begin
            @(negedge clock);
            c++;
        end
        if (busy) chk(1'b0, {"timeout_", tag}, 64'(c), 64'd500);
    endtask

    task automatic do_req(input logic [63:0] va, input logic [63:0] vb);
        wait_idle("before_req");
        @(negedge clock);
        a = va; b = vb; ready_in = 1'b1;
        exp_q.push_back(dsum(va, vb));
        busy = 1'b1;
        @(negedge clock);
        ready_in = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
    endtask

    initial begin
        int     n0;
        int     c;
        longint d;

        // Reset state
        repeat (3) @(negedge clock);
        chk(out === 64'd0, "reset_out", out, 64'd0);
        chk(ready_out === 1'b0, "reset_ready_out", 64'(ready_out), 64'd0);
        chk({input_a_stb, input_b_stb, output_z_ack} === 3'b000, "reset_stb_ack",
            64'({input_a_stb, input_b_stb, output_z_ack}), 64'd0);
        chk(input_a === 64'd0 && input_b === 64'd0, "reset_operands", input_a | input_b, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 1.0 + 2.0 = 3.0
        n0 = n_done;
        do_req(64'h3FF0000000000000, 64'h4000000000000000);
        wait_idle("one_plus_two");
        chk(out === 64'h4008000000000000, "one_plus_two", out, 64'h4008000000000000);
        chk(n_done == n0 + 1, "one_plus_two_pulses", 64'(n_done - n0), 64'd1);

        // 1.23 + 4.56 within 1 ulp of 5.79
        do_req(64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D);
        wait_idle("ulp");
        d = longint'(out) - longint'(64'h401728F5C28F5C29);
        chk(d >= -1 && d <= 1, "sum_5_79_ulp", out, 64'h401728F5C28F5C29);

        // 1.5 + -1.5 = 0.0, one pulse
        n0 = n_done;
        do_req(64'h3FF8000000000000, 64'hBFF8000000000000);
        wait_idle("cancel");
        chk(out === 64'd0, "cancel_to_zero", out, 64'd0);
        chk(n_done == n0 + 1, "cancel_pulses", 64'(n_done - n0), 64'd1);

        // Extra ready_in pulses while waiting on the FPU are ignored
        c_dly = 10;
        n0 = n_done;
        do_req(64'h4014000000000000, 64'h4000000000000000);
        c = 0;
        while (!output_z_ack && c < 100) begin @(negedge clock); c++; end
        chk(output_z_ack === 1'b1, "reach_wait_z", 64'(output_z_ack), 64'd1);
        repeat (3) begin
            a = rnd_dbl(); b = rnd_dbl(); ready_in = 1'b1;
            @(negedge clock);
        end
        ready_in = 1'b0;
        wait_idle("extra_pulses");
        repeat (20) @(negedge clock);
        chk(n_done == n0 + 1, "extra_pulses_ignored", 64'(n_done - n0), 64'd1);
        chk(out === 64'h401C000000000000, "extra_pulses_out", out, 64'h401C000000000000);
        c_dly = 0;

        // Reset asserted while sending B aborts without ready_out
        b_dly = 5;
        n0 = n_done;
        do_req(64'h4024000000000000, 64'h4024000000000000);
        c = 0;
        while (!input_b_stb && c < 100) begin @(negedge clock); c++; end
        chk(input_b_stb === 1'b1, "reach_send_b", 64'(input_b_stb), 64'd1);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk(out === 64'd0 && ready_out === 1'b0, "midop_reset_clears", out, 64'd0);
        chk(input_b_stb === 1'b0, "midop_reset_stb", 64'(input_b_stb), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        chk(n_done == n0, "midop_no_ready_out", 64'(n_done - n0), 64'd0);
        b_dly = 0;
        do_req(64'h3FF0000000000000, 64'h3FF0000000000000);
        wait_idle("after_reset");
        chk(out === 64'h4000000000000000, "after_reset_sum", out, 64'h4000000000000000);

        // Stalled operand acks
        a_dly = 5; b_dly = 5;
        do_req(64'h3FF0000000000000, 64'h4000000000000000);
        wait_idle("stalled");
        chk(out === 64'h4008000000000000, "stalled_sum", out, 64'h4008000000000000);

        // Random operands and stalls, back-to-back where possible
        for (int i = 0; i < 40; i++) begin
            a_dly = $urandom_range(0, 4);
            b_dly = $urandom_range(0, 4);
            c_dly = $urandom_range(0, 6);
            do_req(rnd_dbl(), rnd_dbl());
        end
        wait_idle("random");
        repeat (5) @(negedge clock);
        chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
